// File: rtl/mips_run_ctrl.sv
// Run controller for mips_single_cycle: owns the program RAM, loads it over a
// valid/ready port, and feeds the core instructions, or a jump-to-self while stopped.
module mips_run_ctrl #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic        clk,
  input  logic        asyn_n_rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        start,
  input  logic        step,
  input  logic        halt_req,
  input  logic        abort,
  input  logic        bkpt_en,
  input  logic [31:0] bkpt_pc,
  input  logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        core_n_rst,
  output logic [1:0]  state,
  output logic        done,
  output logic        load_err,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [5:0] OP_J = 6'b000010;

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   prog_len_q;
  logic              core_n_rst_q;
  logic              done_q;
  logic              load_err_q;
  logic [31:0]       cycle_cnt_q;
  logic              resume_skip_q;
  logic              step_mode_q;

  logic [31:0]       imem [IMEM_DEPTH];

  // Loader handshake: a word transfers on a cycle where ld_valid && ld_ready;
  // ld_ready depends only on state, so the host may hold ld_valid freely.
  logic              accept;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] idx;
  logic              past_end;
  logic              bkpt_hit;
  logic              stop_req;
  logic              exec;
  logic [31:0]       spin_word;

  assign ld_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept    = ld_valid && ld_ready;
  assign wr_addr   = (state_q == S_IDLE) ? '0 : wr_ptr_q;

  assign idx       = PC[ADDR_W+1:2];
  assign past_end  = (|PC[31:ADDR_W+2]) || ({1'b0, idx} >= prog_len_q);
  assign bkpt_hit  = bkpt_en && (PC[31:2] == bkpt_pc[31:2]) && !resume_skip_q;
  // A single step ignores halt_req; only the end-of-program check still applies.
  assign stop_req  = !step_mode_q && (halt_req || bkpt_hit);
  assign exec      = (state_q == S_RUN) && !abort && !stop_req && !past_end;
  assign spin_word = {OP_J, PC[27:2]};

  always_comb begin
    instruction = 32'd0;
    case (state_q)
      S_RUN:   instruction = exec ? imem[idx] : spin_word;
      S_HALT:  instruction = spin_word;
      default: instruction = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) imem[wr_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      core_n_rst_q  <= 1'b0;
      done_q        <= 1'b0;
      load_err_q    <= 1'b0;
      cycle_cnt_q   <= 32'd0;
      resume_skip_q <= 1'b0;
      step_mode_q   <= 1'b0;
    end else begin
      resume_skip_q <= 1'b0;
      step_mode_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wr_ptr_q <= ADDR_W'(1);
            if (ld_last) begin
              prog_len_q <= (ADDR_W+1)'(1);
            end else begin
              prog_len_q <= '0;
              state_q    <= S_LOAD;
            end
          end else if (start && (prog_len_q != '0)) begin
            state_q      <= S_RUN;
            core_n_rst_q <= 1'b1;
            done_q       <= 1'b0;
            cycle_cnt_q  <= 32'd0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (ld_last) begin
              prog_len_q <= {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
              state_q    <= S_IDLE;
            end else if (wr_ptr_q == ADDR_W'(IMEM_DEPTH - 1)) begin
              prog_len_q <= (ADDR_W+1)'(IMEM_DEPTH);
              load_err_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q      <= S_IDLE;
            core_n_rst_q <= 1'b0;
          end else if (exec) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (step_mode_q) state_q <= S_HALT;
          end else begin
            state_q <= S_HALT;
            if (!stop_req) done_q <= 1'b1;
          end
        end
        S_HALT: begin
          if (abort) begin
            state_q      <= S_IDLE;
            core_n_rst_q <= 1'b0;
          end else if (!done_q && start) begin
            state_q       <= S_RUN;
            resume_skip_q <= 1'b1;
          end else if (!done_q && step) begin
            state_q       <= S_RUN;
            resume_skip_q <= 1'b1;
            step_mode_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_n_rst = core_n_rst_q;
  assign state      = state_q;
  assign done       = done_q;
  assign load_err   = load_err_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule
